// File: rtl/flit_link_tx.sv
// rtl/flit_link_tx.sv - credit-based flit link transmitter for a mesh router output port
// Optional feature macro: FLIT_TX_CREDIT_BYPASS_EN (a returning credit may fund a send in the same cycle)
module flit_link_tx #(
    parameter int DEPTH  = 8,
    parameter int FLIT_W = 32,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] src_dout,
    input  logic              src_empty,
    output logic              src_rd_en,
    output logic [FLIT_W-1:0] tx_flit,
    output logic              tx_valid,
    input  logic              credit_in,
    output logic [CW-1:0]     credits,
    output logic              credit_err
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]     r_credits;
    logic              r_credit_err;
    logic [FLIT_W-1:0] r_tx_flit;
    logic              r_tx_valid;

    logic              w_avail;
    logic              w_send;
    logic              w_overflow;
    logic [CW-1:0]     w_credits_nxt;

`ifdef FLIT_TX_CREDIT_BYPASS_EN
    assign w_avail = (r_credits != '0) | credit_in;
`else
    assign w_avail = (r_credits != '0);
`endif

    assign w_send     = ~reset & ~src_empty & w_avail;
    // A return with the counter already full and nothing leaving means the receiver over-returned.
    assign w_overflow = credit_in & ~w_send & (r_credits == DEPTH_C);

    always_comb begin
        w_credits_nxt = r_credits - CW'(w_send) + CW'(credit_in);
        if (w_overflow) begin
            w_credits_nxt = DEPTH_C;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_flit    <= '0;
            r_tx_valid   <= 1'b0;
            r_credits    <= DEPTH_C;
            r_credit_err <= 1'b0;
        end else begin
            r_tx_valid <= w_send;
            if (w_send) begin
                r_tx_flit <= src_dout;
            end
            r_credits <= w_credits_nxt;
            if (w_overflow) begin
                r_credit_err <= 1'b1;
            end
        end
    end

    assign src_rd_en  = w_send;
    assign tx_flit    = r_tx_flit;
    assign tx_valid   = r_tx_valid;
    assign credits    = r_credits;
    assign credit_err = r_credit_err;

endmodule
